// File: rtl/piso_serial_tx_if.sv
// Word handshake and serial-link signals of piso_serial_tx.
// The master side (upstream logic) drives Load/Din. The slave side (the transmitter) drives the rest.
interface piso_serial_tx_if #(
  parameter int WIDTH = 8
);
  logic             Load;
  logic [WIDTH-1:0] Din;
  logic             Ready;
  logic             SerOut;
  logic             Frame;
  logic             Done;

  modport master (
    output Load, Din,
    input  Ready, SerOut, Frame, Done
  );

  modport slave (
    input  Load, Din,
    output Ready, SerOut, Frame, Done
  );
endinterface

// File: rtl/piso_serial_tx.sv
// Parallel-in/serial-out transmitter: Load/Ready word handshake, DIV clocks per bit, idle-high line.
// Optional even-parity bit after the data bits when PISO_TX_PARITY_EN is defined.
module piso_serial_tx #(
  parameter int WIDTH     = 8,
  parameter int DIV       = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             Clock,
  input  logic             Reset,
  piso_serial_tx_if.slave  tx
);

  localparam int DW = (DIV   > 1) ? $clog2(DIV)   : 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
`ifdef PISO_TX_PARITY_EN
  localparam logic [1:0] ST_PAR   = 2'd2;
`endif

  logic [1:0]       state;
  logic [WIDTH-1:0] sreg;
  logic [DW-1:0]    div_cnt;
  logic [BW-1:0]    bit_cnt;
  logic             done_q;
`ifdef PISO_TX_PARITY_EN
  logic             parity_q;
`endif

  // The output end of the register is the bit currently on the line.
  function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] r);
    if (MSB_FIRST) return {r[WIDTH-2:0], 1'b0};
    else           return {1'b0, r[WIDTH-1:1]};
  endfunction

  // NOTE: all state here is plain flops, so every register gets the async reset value;
  // non-blocking assignments keep the updates order-independent within the edge.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state    <= ST_IDLE;
      sreg     <= '0;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      done_q   <= 1'b0;
`ifdef PISO_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (tx.Load) begin
            sreg     <= tx.Din;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            state    <= ST_SHIFT;
`ifdef PISO_TX_PARITY_EN
            parity_q <= ^tx.Din;
`endif
          end
        end

        ST_SHIFT: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            sreg    <= shift_out(sreg);
            if (bit_cnt == BIT_LAST) begin
              bit_cnt <= '0;
`ifdef PISO_TX_PARITY_EN
              state   <= ST_PAR;
`else
              state   <= ST_IDLE;
              done_q  <= 1'b1;
`endif
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

`ifdef PISO_TX_PARITY_EN
        ST_PAR: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            state   <= ST_IDLE;
            done_q  <= 1'b1;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
`endif

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign tx.Ready = (state == ST_IDLE);
  assign tx.Frame = (state != ST_IDLE);
  assign tx.Done  = done_q;

  always_comb begin
    tx.SerOut = 1'b1;
    case (state)
      ST_SHIFT: tx.SerOut = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];
`ifdef PISO_TX_PARITY_EN
      ST_PAR:   tx.SerOut = parity_q;
`endif
      default:  tx.SerOut = 1'b1;
    endcase
  end

endmodule
